// File: rtl/scroll_if.sv
// Request, RAM and status signals between cursor control, the scroll engine and the text RAM.
interface scroll_if #(
  parameter int unsigned CELL_W = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              req_valid;
  logic              req_dir;
  logic [7:0]        req_step;
  logic [7:0]        req_top;
  logic [7:0]        req_bottom;
  logic              abort;
  logic [CELL_W-1:0] blank_cell;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CELL_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CELL_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output req_valid, req_dir, req_step, req_top, req_bottom, abort, blank_cell, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, overflow
  );

  modport slave (
    input  req_valid, req_dir, req_step, req_top, req_bottom, abort, blank_cell, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, overflow
  );
endinterface

// File: rtl/scroll_engine.sv
// Scroll engine: moves rows of the text RAM inside [top, bottom], then blanks vacated rows.
// One cell per cycle through a 1-deep write stage; holds one pending request.
module scroll_engine #(
  parameter int unsigned COLS   = 80,
  parameter int unsigned LINES  = 24,
  parameter int unsigned CELL_W = 32,
  parameter int unsigned ADDR_W = 12
) (
  input logic     clk,
  input logic     rst,
  scroll_if.slave bus
);

  localparam int unsigned RW = 8;
  localparam logic [RW-1:0] LAST_COL = RW'(COLS - 1);

  typedef enum logic [2:0] {S_IDLE, S_COPY, S_CLEAR, S_FLUSH, S_DONE} state_e;

  typedef struct packed {
    logic          dir;
    logic [RW-1:0] step;
    logic [RW-1:0] top;
    logic [RW-1:0] bottom;
  } req_t;

  state_e            state_q, state_d;
  req_t              cur_q, cur_d;
  req_t              pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic [RW-1:0]     row_q, row_d;
  logic [RW-1:0]     col_q, col_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              wr_blank_q, wr_blank_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              start_c;
  req_t              in_req_c, start_req_c;
  logic [RW:0]       span_c;
  logic [RW-1:0]     step_c;
  logic [CELL_W-1:0] wr_data_c;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [RW-1:0] r, input logic [RW-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  function automatic logic region_ok(input req_t r);
    return (r.top <= r.bottom) && (32'(r.bottom) < LINES);
  endfunction

  function automatic logic [RW-1:0] norm_step(input req_t r, input logic [RW:0] span);
    if (r.step == '0) return RW'(1);
    if ((RW+1)'(r.step) > span) return RW'(span);
    return r.step;
  endfunction

  function automatic logic [RW-1:0] src_row(input req_t r, input logic [RW-1:0] row);
    return r.dir ? row - r.step : row + r.step;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_blank_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_blank_q <= wr_blank_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    row_d       = row_q;
    col_d       = col_q;
    ovf_d       = ovf_q;
    start_c     = 1'b0;
    in_req_c    = '{dir: bus.req_dir, step: bus.req_step, top: bus.req_top, bottom: bus.req_bottom};
    start_req_c = in_req_c;
    span_c      = '0;
    step_c      = '0;

    case (state_q)
      S_IDLE: start_c = bus.req_valid;
      S_COPY, S_CLEAR: begin
        if (col_q == LAST_COL) begin
          col_d = '0;
          if (!cur_q.dir) begin
            // Up: one ascending sweep, copy rows first then the vacated tail.
            if (row_q == cur_q.bottom) begin
              state_d = S_FLUSH;
            end else begin
              row_d   = row_q + RW'(1);
              state_d = ((RW+1)'(row_d) + (RW+1)'(cur_q.step) <= (RW+1)'(cur_q.bottom)) ? S_COPY : S_CLEAR;
            end
          end else if (state_q == S_COPY) begin
            // Down: descending copy, then restart at top for an ascending clear.
            if (row_q == cur_q.top + cur_q.step) begin
              row_d   = cur_q.top;
              state_d = S_CLEAR;
            end else begin
              row_d = row_q - RW'(1);
            end
          end else begin
            if (row_q == cur_q.top + cur_q.step - RW'(1)) state_d = S_FLUSH;
            else                                          row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + RW'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        if (pend_vld_q) begin
          start_c     = 1'b1;
          start_req_c = pend_q;
          pend_vld_d  = 1'b0;
        end else begin
          start_c = bus.req_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Requests arriving mid-operation fill the slot or are dropped.
    if (bus.req_valid && ((state_q inside {S_COPY, S_CLEAR, S_FLUSH}) || (state_q == S_DONE && pend_vld_q))) begin
      if (!pend_vld_q) begin
        pend_vld_d = 1'b1;
        pend_d     = in_req_c;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (start_c) begin
      if (!region_ok(start_req_c)) begin
        state_d = S_DONE;
      end else begin
        span_c     = (RW+1)'(start_req_c.bottom) - (RW+1)'(start_req_c.top) + (RW+1)'(1);
        step_c     = norm_step(start_req_c, span_c);
        cur_d      = start_req_c;
        cur_d.step = step_c;
        col_d      = '0;
        if ((RW+1)'(step_c) < span_c) begin
          state_d = S_COPY;
          row_d   = start_req_c.dir ? start_req_c.bottom : start_req_c.top;
        end else begin
          state_d = S_CLEAR;
          row_d   = start_req_c.top;
        end
      end
    end

    if (bus.abort) begin
      state_d    = S_IDLE;
      pend_vld_d = 1'b0;
      ovf_d      = ovf_q;
      pend_d     = pend_q;
    end

    rd_en_d    = (state_d == S_COPY);
    rd_addr_d  = rd_en_d ? cell_addr(src_row(cur_d, row_d), col_d) : '0;
    wr_en_d    = !bus.abort && (state_q inside {S_COPY, S_CLEAR});
    wr_addr_d  = wr_en_d ? cell_addr(row_q, col_q) : '0;
    wr_blank_d = wr_en_d && (state_q == S_CLEAR);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // Write data joins the RAM read that returns in the write cycle.
  assign wr_data_c = !wr_en_q ? '0 : (wr_blank_q ? bus.blank_cell : bus.rd_data);

  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_c;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_scroll_engine.sv
// Scoreboard bench for scroll_engine: expected RAM writes and done cycles are queued at
// stimulus time and checked by an independent monitor against a behavioural RAM.
`timescale 1ns/1ps
module tb_scroll_engine;
  localparam int C      = 80;
  localparam int L      = 24;
  localparam int NCELL  = C * L;
  localparam int CELL_W = 32;
  localparam int ADDR_W = 12;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [CELL_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic load;
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  int   rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0;

  logic [CELL_W-1:0] ram [NCELL];
  logic [CELL_W-1:0] sh  [NCELL];
  wr_t wq[$];
  int  dq[$];

  always #5 clk = ~clk;

  scroll_if #(.CELL_W(CELL_W), .ADDR_W(ADDR_W)) bus();

  scroll_engine #(.COLS(C), .LINES(L), .CELL_W(CELL_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [CELL_W-1:0] init_val(input int i);
    return 32'((i / C) * 256 + (i % C));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port text RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NCELL; i++) ram[i] <= init_val(i);
    end else begin
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
      if (bus.wr_en) ram[bus.wr_addr] <= bus.wr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        compared++;
        if (wq.size() == 0) begin
          failed++;
          $display("FAIL unexpected_write: addr=%0d data=%h at cycle %0d", bus.wr_addr, bus.wr_data, cyc);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
            failed++;
            $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h", bus.wr_addr, bus.wr_data, e.addr, e.data);
          end
        end
      end
      if (bus.done) begin
        compared++;
        if (dq.size() == 0) begin
          failed++;
          $display("FAIL unexpected_done: at cycle %0d", cyc);
        end else begin
          int e;
          e = dq.pop_front();
          if (cyc != e) begin
            failed++;
            $display("FAIL done_cycle: got %0d expected %0d", cyc, e);
          end
        end
      end
      rd_cnt   += int'(bus.rd_en);
      wr_cnt   += int'(bus.wr_en);
      busy_cnt += int'(bus.busy);
      done_cnt += int'(bus.done);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic put(input int a, input logic [CELL_W-1:0] v, input int lim, inout int cnt);
    if (cnt < lim) begin
      wq.push_back('{addr: ADDR_W'(a), data: v});
      sh[a] = v;
    end
    cnt++;
  endtask

  // Cell-level scroll in the documented order; only the first lim writes are queued/applied.
  task automatic model(input bit dir, input int step, input int top, input int bottom,
                       input logic [CELL_W-1:0] blank, input int lim, output int n);
    int h, s, cnt;
    cnt = 0;
    n = 0;
    if (top > bottom || bottom >= L) return;
    h = bottom - top + 1;
    s = (step == 0) ? 1 : ((step > h) ? h : step);
    n = h * C;
    if (!dir) begin
      for (int d = top; d <= bottom - s; d++)
        for (int c = 0; c < C; c++) put(d * C + c, sh[(d + s) * C + c], lim, cnt);
      for (int d = bottom - s + 1; d <= bottom; d++)
        for (int c = 0; c < C; c++) put(d * C + c, blank, lim, cnt);
    end else begin
      for (int d = bottom; d >= top + s; d--)
        for (int c = 0; c < C; c++) put(d * C + c, sh[(d - s) * C + c], lim, cnt);
      for (int d = top; d <= top + s - 1; d++)
        for (int c = 0; c < C; c++) put(d * C + c, blank, lim, cnt);
    end
  endtask

  task automatic reload();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int i = 0; i < NCELL; i++) sh[i] = init_val(i);
  endtask

  task automatic pulse_req(input bit dir, input logic [7:0] step, input logic [7:0] top, input logic [7:0] bottom);
    bus.req_dir    = dir;
    bus.req_step   = step;
    bus.req_top    = top;
    bus.req_bottom = bottom;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || wq.size() != 0 || dq.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (n >= limit) begin
      compared++;
      failed++;
      $display("FAIL timeout: busy=%0d writes_left=%0d dones_left=%0d", bus.busy, wq.size(), dq.size());
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, rd0, wr0, busy0, done0;
    rst = 1'b1;
    load = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_dir = 1'b0;
    bus.req_step = '0;
    bus.req_top = '0;
    bus.req_bottom = '0;
    bus.abort = 1'b0;
    bus.blank_cell = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_overflow", 64'(bus.overflow), 0);
    check("rst_rd_en", 64'(bus.rd_en), 0);
    check("rst_wr_en", 64'(bus.wr_en), 0);
    check("rst_wr_data", 64'(bus.wr_data), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: full-screen up by one row
    reload();
    bus.blank_cell = 32'hDEAD_0020;
    wr0 = wr_cnt;
    @(negedge clk);
    k = cyc;
    model(1'b0, 1, 0, 23, bus.blank_cell, NCELL, n);
    dq.push_back(k + n + 2);
    pulse_req(1'b0, 8'd1, 8'd0, 8'd23);
    wait_idle(4000);
    check("t1_wr_count", 64'(wr_cnt - wr0), 1920);
    check("t1_row0", 64'(ram[0]), 64'h100);
    check("t1_row22", 64'(ram[22 * C + 79]), 64'(23 * 256 + 79));
    check("t1_row23", 64'(ram[23 * C + 5]), 64'hDEAD_0020);

    // 2: down by two in rows 5..10
    reload();
    bus.blank_cell = 32'hB1A4_0002;
    @(negedge clk);
    k = cyc;
    model(1'b1, 2, 5, 10, bus.blank_cell, NCELL, n);
    dq.push_back(k + n + 2);
    pulse_req(1'b1, 8'd2, 8'd5, 8'd10);
    wait_idle(1000);
    check("t2_row10", 64'(ram[10 * C]), 64'(8 * 256));
    check("t2_row7", 64'(ram[7 * C + 3]), 64'(5 * 256 + 3));
    check("t2_row5_blank", 64'(ram[5 * C + 79]), 64'hB1A4_0002);
    check("t2_row6_blank", 64'(ram[6 * C]), 64'hB1A4_0002);
    check("t2_row4_kept", 64'(ram[4 * C + 7]), 64'(4 * 256 + 7));
    check("t2_row11_kept", 64'(ram[11 * C]), 64'(11 * 256));

    // 3a: step 0 behaves as 1
    reload();
    bus.blank_cell = 32'hC0C0_0003;
    @(negedge clk);
    k = cyc;
    model(1'b0, 0, 3, 6, bus.blank_cell, NCELL, n);
    dq.push_back(k + n + 2);
    pulse_req(1'b0, 8'd0, 8'd3, 8'd6);
    wait_idle(1000);
    check("t3a_row3", 64'(ram[3 * C]), 64'(4 * 256));
    check("t3a_row5", 64'(ram[5 * C + 1]), 64'(6 * 256 + 1));
    check("t3a_row6_blank", 64'(ram[6 * C + 2]), 64'hC0C0_0003);
    check("t3a_row2_kept", 64'(ram[2 * C]), 64'(2 * 256));

    // 3b: oversized step clears the whole region without reads
    reload();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    k = cyc;
    model(1'b0, 200, 3, 6, bus.blank_cell, NCELL, n);
    dq.push_back(k + 4 * C + 2);
    pulse_req(1'b0, 8'd200, 8'd3, 8'd6);
    wait_idle(1000);
    check("t3b_rd_count", 64'(rd_cnt - rd0), 0);
    check("t3b_wr_count", 64'(wr_cnt - wr0), 64'(4 * C));
    check("t3b_row3_blank", 64'(ram[3 * C]), 64'hC0C0_0003);
    check("t3b_row7_kept", 64'(ram[7 * C]), 64'(7 * 256));

    // 4: invalid regions (top > bottom, bottom past the screen)
    for (int t = 0; t < 2; t++) begin
      rd0 = rd_cnt;
      wr0 = wr_cnt;
      busy0 = busy_cnt;
      @(negedge clk);
      k = cyc;
      dq.push_back(k + 1);
      if (t == 0) pulse_req(1'b0, 8'd1, 8'd10, 8'd4);
      else        pulse_req(1'b1, 8'd1, 8'd20, 8'd24);
      wait_idle(100);
      check("t4_rd_count", 64'(rd_cnt - rd0), 0);
      check("t4_wr_count", 64'(wr_cnt - wr0), 0);
      check("t4_busy_cycles", 64'(busy_cnt - busy0), 1);
    end

    // 5: one pending, one dropped
    reload();
    bus.blank_cell = 32'h5555_0005;
    busy0 = busy_cnt;
    done0 = done_cnt;
    @(negedge clk);
    k = cyc;
    model(1'b1, 1, 0, 3, bus.blank_cell, NCELL, n);
    dq.push_back(k + n + 2);
    pulse_req(1'b1, 8'd1, 8'd0, 8'd3);
    wait_cyc(k + 5);
    model(1'b0, 2, 12, 15, bus.blank_cell, NCELL, n);
    dq.push_back(k + 4 * C + 2 + n + 2);
    pulse_req(1'b0, 8'd2, 8'd12, 8'd15);
    wait_cyc(k + 10);
    pulse_req(1'b0, 8'd1, 8'd18, 8'd23);
    wait_idle(2000);
    check("t5_overflow", 64'(bus.overflow), 1);
    check("t5_done_count", 64'(done_cnt - done0), 2);
    check("t5_busy_cycles", 64'(busy_cnt - busy0), 64'(2 * (4 * C + 2)));
    check("t5_row3", 64'(ram[3 * C]), 64'(2 * 256));
    check("t5_row0_blank", 64'(ram[0]), 64'h5555_0005);
    check("t5_row12", 64'(ram[12 * C]), 64'(14 * 256));
    check("t5_row15_blank", 64'(ram[15 * C]), 64'h5555_0005);
    check("t5_row18_kept", 64'(ram[18 * C]), 64'(18 * 256));

    // 6: abort at issue cycle 100 with a pending request
    reload();
    bus.blank_cell = 32'hABAB_0006;
    done0 = done_cnt;
    @(negedge clk);
    k = cyc;
    model(1'b0, 1, 0, 23, bus.blank_cell, 99, n);
    pulse_req(1'b0, 8'd1, 8'd0, 8'd23);
    wait_cyc(k + 10);
    pulse_req(1'b1, 8'd2, 8'd3, 8'd9);
    wait_cyc(k + 100);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t6_busy_after_abort", 64'(bus.busy), 0);
    check("t6_wr_after_abort", 64'(bus.wr_en), 0);
    repeat (40) @(negedge clk);
    check("t6_busy_stays_low", 64'(bus.busy), 0);
    check("t6_writes_left", 64'(wq.size()), 0);
    check("t6_no_done", 64'(done_cnt - done0), 0);
    check("t6_row0", 64'(ram[79]), 64'(256 + 79));
    check("t6_row1_written", 64'(ram[C + 18]), 64'(2 * 256 + 18));
    check("t6_row1_kept", 64'(ram[C + 19]), 64'(256 + 19));
    @(negedge clk);
    k = cyc;
    model(1'b1, 3, 2, 9, bus.blank_cell, NCELL, n);
    dq.push_back(k + n + 2);
    pulse_req(1'b1, 8'd3, 8'd2, 8'd9);
    wait_idle(2000);
    check("t6_row9", 64'(ram[9 * C]), 64'(6 * 256));
    check("t6_row5", 64'(ram[5 * C + 1]), 64'(2 * 256 + 1));
    check("t6_row2_blank", 64'(ram[2 * C]), 64'hABAB_0006);
    check("t6_row4_blank", 64'(ram[4 * C + 79]), 64'hABAB_0006);
    check("t6_row10_kept", 64'(ram[10 * C]), 64'(10 * 256));
    check("t6_overflow_sticky", 64'(bus.overflow), 1);

    check("end_writes_left", 64'(wq.size()), 0);
    check("end_dones_left", 64'(dq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/scroll_engine.md
Name: scroll_engine

Overview:
- Executes scroll requests from the cursor-control stage by moving rows of the text buffer RAM inside the scroll region [top, bottom].
- Copies surviving rows, then fills vacated rows with a blank cell at one cell per cycle.
- Sits between cursor control (request producer) and the dual-port text RAM, which the renderer also reads.
- Buffers one pending request because the upstream stage cannot stall.

Parameters:
- COLS, 80, cells per row
- LINES, 24, rows on screen
- CELL_W, 32, bits per text cell (char + attributes)
- ADDR_W, 12, linear RAM address width (address = row*COLS + col)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  1  single-cycle scroll request strobe
- req_dir  in  1  0 = up (content moves toward top), 1 = down
- req_step  in  8  rows to scroll
- req_top  in  8  first row of region
- req_bottom  in  8  last row of region
- abort  in  1  cancel active and pending work
- blank_cell  in  CELL_W  fill value for vacated rows, sampled per write
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  CELL_W  RAM read data, valid one cycle after rd_en
- wr_en  out  1  RAM write strobe
- wr_addr  out  ADDR_W  RAM write address
- wr_data  out  CELL_W  RAM write data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky: a request was dropped

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
  - All outputs are 0 on reset.
  - FSM goes to IDLE.
  - Pending slot is cleared.
- States:
  - IDLE: no work.
  - COPY: issue reads for rows being moved.
  - CLEAR: issue blank writes for vacated rows.
  - FLUSH: wait for the last write to retire.
  - DONE: done pulse.
- Acceptance: in IDLE, req_valid latches dir, step, top and bottom. COPY (or CLEAR) begins the next cycle.
- Request while busy or in DONE:
  - Stored in the pending slot if the slot is empty.
  - Otherwise dropped and overflow is set; overflow clears only on rst.
- Pending start: a pending request starts in the cycle after DONE, with no IDLE cycle in between.
- Invalid region (top > bottom, or bottom >= LINES):
  - No RAM traffic.
  - done pulses in the cycle after acceptance.
- Step normalisation: H = bottom - top + 1; S = (step == 0) ? 1 : min(step, H).
- Up scroll:
  - For dst = top .. bottom-S in ascending order, copy row dst+S to row dst, col 0..COLS-1.
  - Then clear rows bottom-S+1 .. bottom.
- Down scroll:
  - For dst = bottom .. top+S in descending order, copy row dst-S to row dst.
  - Then clear rows top .. top+S-1.
- Hazard avoidance: the copy order guarantees every source row is read before it is overwritten.
- Copy pipeline:
  - Each COPY cycle asserts rd_en with the source address and pushes the destination address into a 1-deep write stage.
  - The next cycle asserts wr_en with wr_data = rd_data.
  - Throughput is one cell per cycle.
- Clear pipeline:
  - Each CLEAR cycle pushes a blank token (destination address) into the same write stage; rd_en stays low.
  - The next cycle writes blank_cell.
- Timing:
  - Issue cycles N = H*COLS in total, contiguous. The COPY-to-CLEAR transition has no bubble.
  - wr_en follows each issue by exactly one cycle.
  - FLUSH is the cycle of the last write.
  - done is high in the following cycle.
  - Total from acceptance edge to done cycle = N + 2 cycles.
- busy is high from the first issue cycle through the done cycle inclusive.
- Address arithmetic: row*COLS + col is computed at ADDR_W width. Row and column counters are 8-bit and wrap only at the limits above.
- abort (highest priority):
  - Next state is IDLE; pending is cleared; busy drops the next cycle; no done pulse.
  - An in-flight write-stage entry is discarded; RAM may be left partially scrolled.
  - A req_valid in the same cycle as abort is ignored.
- rst mid-operation: same effect as abort, but asynchronous.

Test Plan:
1. Up, step=1, top=0, bottom=23, row r preloaded with value r -> rows 0..22 hold r+1, row 23 = blank_cell; wr_en count 1920; done exactly 1922 cycles after acceptance.
2. Down, step=2, top=5, bottom=10 -> rows 7..10 hold old rows 5..8, rows 5..6 blank, rows 0..4 and 11..23 untouched; first copy writes row 10 from row 8.
3. step=0 and step=200 on region top=3, bottom=6 -> step 0 acts as 1; step 200 clears rows 3..6 with rd_en never asserted; done after 4*80+2 cycles.
4. top=10, bottom=4 -> no rd_en/wr_en; done the cycle after acceptance; busy high for that cycle only.
5. Three req_valid pulses during one active operation -> second request runs immediately after first done; third dropped; overflow = 1.
6. abort at issue cycle 100 with a pending request -> busy low the next cycle; no done; pending discarded; a new request afterwards completes normally.
